// File: rtl/acc_ctrl_pkg.sv
// Shared types and defaults for the accumulator capture-and-drain controller.
package acc_ctrl_pkg;

  localparam int NUM_ENTRIES_DEF = 8;
  localparam int DATA_W_DEF      = 16;
  localparam int ADDR_W_DEF      = 8;
  localparam int IDX_W_DEF       = $clog2(NUM_ENTRIES_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAT,
    ST_FEED,
    ST_WAIT_FULL,
    ST_DRAIN,
    ST_DONE
  } acc_drain_state_t;

  // Entry idx of a packed accumulator bus, entry 0 in the LSBs.
  function automatic logic [DATA_W_DEF-1:0] acc_entry(
    input logic [NUM_ENTRIES_DEF*DATA_W_DEF-1:0] bus,
    input logic [IDX_W_DEF-1:0]                  idx
  );
    return bus[idx*DATA_W_DEF +: DATA_W_DEF];
  endfunction

endpackage

// File: rtl/acc_snapshot_reg.sv
// Capture register holding one full accumulator image, with an indexed read mux.
module acc_snapshot_reg
  import acc_ctrl_pkg::*;
#(
  parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int IDX_W       = IDX_W_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [NUM_ENTRIES*DATA_W-1:0] load_data,
  input  logic [IDX_W-1:0]              rd_idx,
  output logic [DATA_W-1:0]             rd_data
);

  logic [NUM_ENTRIES*DATA_W-1:0] snap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q <= '0;
    end else if (load) begin
      snap_q <= load_data;
    end
  end

  generate
    if (NUM_ENTRIES == NUM_ENTRIES_DEF && DATA_W == DATA_W_DEF && IDX_W == IDX_W_DEF) begin : g_def
      always_comb rd_data = acc_entry(snap_q, rd_idx);
    end else begin : g_gen
      always_comb rd_data = snap_q[rd_idx*DATA_W +: DATA_W];
    end
  endgenerate

endmodule

// File: rtl/acc_drain_ctrl.sv
// Sequences one accumulator capture and drains it into the unified buffer.
// Optional WAIT_FULL timeout enabled by defining ACC_DRAIN_TIMEOUT_EN.
module acc_drain_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int NUM_ENTRIES  = NUM_ENTRIES_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int ARRAY_LAT    = 4,
  parameter int FULL_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          acc_valid,
  output logic                          acc_output_valid,
  input  logic                          acc_full,
  input  logic [NUM_ENTRIES*DATA_W-1:0] acc_data,
  output logic                          ub_wr_en,
  input  logic                          ub_wr_ready,
  output logic [ADDR_W-1:0]             ub_wr_addr,
  output logic [DATA_W-1:0]             ub_wr_data
);

  localparam int IDX_W   = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int MAX_A   = (ARRAY_LAT > NUM_ENTRIES) ? ARRAY_LAT : NUM_ENTRIES;
  localparam int CNT_MAX = (FULL_TIMEOUT > MAX_A) ? FULL_TIMEOUT : MAX_A;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  acc_drain_state_t  state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] base_q;
  logic              snap_load;

  assign snap_load = (state_q == ST_WAIT_FULL) && acc_full;

  acc_snapshot_reg #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .DATA_W     (DATA_W),
    .IDX_W      (IDX_W)
  ) u_snap (
    .clk      (clk),
    .reset    (reset),
    .load     (snap_load),
    .load_data(acc_data),
    .rd_idx   (idx_q),
    .rd_data  (ub_wr_data)
  );

  always_comb ub_wr_addr = base_q + ADDR_W'(idx_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      idx_q            <= '0;
      base_q           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      acc_valid        <= 1'b0;
      acc_output_valid <= 1'b0;
      ub_wr_en         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (acc_full) begin
              err <= 1'b1;
            end else begin
              err       <= 1'b0;
              base_q    <= base_addr;
              busy      <= 1'b1;
              acc_valid <= 1'b1;
              cnt_q     <= '0;
              if (ARRAY_LAT == 0) begin
                state_q          <= ST_FEED;
                acc_output_valid <= 1'b1;
              end else begin
                state_q <= ST_LAT;
              end
            end
          end
        end
        ST_LAT: begin
          if (cnt_q == CNT_W'(ARRAY_LAT - 1)) begin
            cnt_q            <= '0;
            state_q          <= ST_FEED;
            acc_output_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_FEED: begin
          if (cnt_q == CNT_W'(NUM_ENTRIES - 1)) begin
            cnt_q            <= '0;
            state_q          <= ST_WAIT_FULL;
            acc_output_valid <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_FULL: begin
          if (acc_full) begin
            acc_valid <= 1'b0;
            ub_wr_en  <= 1'b1;
            idx_q     <= '0;
            state_q   <= ST_DRAIN;
          end
`ifdef ACC_DRAIN_TIMEOUT_EN
          else if (cnt_q == CNT_W'(FULL_TIMEOUT - 1)) begin
            // Abort reuses DONE so busy/done sequencing matches a normal finish.
            acc_valid <= 1'b0;
            err       <= 1'b1;
            done      <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        ST_DRAIN: begin
          if (ub_wr_ready) begin
            if (idx_q == IDX_W'(NUM_ENTRIES - 1)) begin
              ub_wr_en <= 1'b0;
              done     <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_drain_ctrl.sv
// Directed self-checking bench for acc_drain_ctrl (8 entries, 16-bit, ARRAY_LAT=4).
module tb_acc_drain_ctrl;

  logic         clk = 1'b0;
  logic         reset, start, acc_full, ub_wr_ready;
  logic [7:0]   base_addr;
  logic [127:0] acc_data;
  logic         busy, done, err, acc_valid, acc_output_valid, ub_wr_en;
  logic [7:0]   ub_wr_addr;
  logic [15:0]  ub_wr_data;

  int errors = 0;
  int checks = 0;
  int n_wr, hold_viol, last_k, done_k;
  logic [7:0]  wa [16];
  logic [15:0] wd [16];

  always #5 clk = ~clk;

  acc_drain_ctrl #(
    .NUM_ENTRIES (8),
    .DATA_W      (16),
    .ADDR_W      (8),
    .ARRAY_LAT   (4),
    .FULL_TIMEOUT(64)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .base_addr       (base_addr),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .acc_valid       (acc_valid),
    .acc_output_valid(acc_output_valid),
    .acc_full        (acc_full),
    .acc_data        (acc_data),
    .ub_wr_en        (ub_wr_en),
    .ub_wr_ready     (ub_wr_ready),
    .ub_wr_addr      (ub_wr_addr),
    .ub_wr_data      (ub_wr_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [15:0] seed);
    for (int i = 0; i < 8; i++) acc_data[i*16 +: 16] = seed + 16'(i);
  endtask

  // Leaves the bench one cycle after the accepting edge (first LAT cycle).
  task automatic start_job(input logic [7:0] b);
    base_addr = b;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // From cycle from_j of a job, raise acc_full in the third WAIT_FULL cycle; ends in first DRAIN cycle.
  task automatic advance_to_drain(input int from_j);
    repeat (14 - from_j) tick();
    acc_full = 1'b1;
    tick();
    acc_full = 1'b0;
  endtask

  // Records accepted writes and hold violations until done or a cycle budget expires.
  task automatic collect(input int mode);
    logic       pend;
    logic [7:0] pa;
    logic [15:0] pd;
    n_wr = 0; hold_viol = 0; last_k = -1; done_k = -1; pend = 1'b0;
    for (int k = 0; k < 200; k++) begin
      ub_wr_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      if (pend && (ub_wr_en !== 1'b1 || ub_wr_addr !== pa || ub_wr_data !== pd)) hold_viol++;
      pend = 1'b0;
      if (ub_wr_en === 1'b1) begin
        if (ub_wr_ready) begin
          if (n_wr < 16) begin wa[n_wr] = ub_wr_addr; wd[n_wr] = ub_wr_data; end
          n_wr++;
          last_k = k;
        end else begin
          pend = 1'b1; pa = ub_wr_addr; pd = ub_wr_data;
        end
      end
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      tick();
    end
    ub_wr_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (acc_valid !== 1'b0 || acc_output_valid !== 1'b0) begin errors++; $display("FAIL rst_acc: got %b%b want 00", acc_valid, acc_output_valid); end
    checks++; if (ub_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", ub_wr_en); end
    checks++; if (ub_wr_addr !== 8'h00 || ub_wr_data !== 16'h0000) begin errors++; $display("FAIL rst_addr_data: got %h/%h want 00/0000", ub_wr_addr, ub_wr_data); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic ok;
    set_data(16'h0001);
    start_job(8'h10);
    checks++; if (busy !== 1'b1 || acc_valid !== 1'b1 || acc_output_valid !== 1'b0) begin errors++; $display("FAIL basic_lat_entry: got busy=%b av=%b aov=%b want 1 1 0", busy, acc_valid, acc_output_valid); end
    ok = 1'b1;
    for (int j = 1; j <= 3; j++) begin tick(); if (acc_output_valid !== 1'b0 || acc_valid !== 1'b1) ok = 1'b0; end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_lat_hold: got early aov want 4 LAT cycles"); end
    ok = 1'b1;
    for (int j = 4; j <= 11; j++) begin tick(); if (acc_output_valid !== 1'b1 || acc_valid !== 1'b1) ok = 1'b0; end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_feed_8: got gap in aov want 8 cycles high"); end
    tick();
    checks++; if (acc_output_valid !== 1'b0 || acc_valid !== 1'b1) begin errors++; $display("FAIL basic_wait_full: got av=%b aov=%b want 1 0", acc_valid, acc_output_valid); end
    tick(); tick();
    acc_full = 1'b1;
    tick();
    acc_full = 1'b0;
    checks++; if (ub_wr_en !== 1'b1 || acc_valid !== 1'b0) begin errors++; $display("FAIL basic_drain_entry: got en=%b av=%b want 1 0", ub_wr_en, acc_valid); end
    collect(0);
    checks++; if (n_wr !== 8) begin errors++; $display("FAIL basic_nwr: got %0d want 8", n_wr); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wa[i] !== 8'h10 + 8'(i) || wd[i] !== 16'(i + 1)) begin errors++; $display("FAIL basic_wr%0d: got %h/%h want %h/%h", i, wa[i], wd[i], 8'h10 + 8'(i), 16'(i + 1)); end
    end
    checks++; if (done_k !== 8 || last_k !== 7) begin errors++; $display("FAIL basic_done_latency: got done_k=%0d last_k=%0d want 8 7", done_k, last_k); end
    checks++; if (busy !== 1'b1 || ub_wr_en !== 1'b0) begin errors++; $display("FAIL basic_done_cycle: got busy=%b en=%b want 1 0", busy, ub_wr_en); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle_after: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_backpressure();
    set_data(16'hA000);
    start_job(8'h40);
    advance_to_drain(0);
    collect(1);
    checks++; if (n_wr !== 8) begin errors++; $display("FAIL bp_nwr: got %0d want 8", n_wr); end
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL bp_hold: got %0d violations want 0", hold_viol); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wa[i] !== 8'h40 + 8'(i) || wd[i] !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL bp_wr%0d: got %h/%h want %h/%h", i, wa[i], wd[i], 8'h40 + 8'(i), 16'hA000 + 16'(i)); end
    end
    checks++; if (last_k !== 15 || done_k !== 16) begin errors++; $display("FAIL bp_timing: got last_k=%0d done_k=%0d want 15 16", last_k, done_k); end
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a [8];
    exp_a = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
    set_data(16'h5550);
    start_job(8'hFC);
    advance_to_drain(0);
    collect(0);
    checks++; if (n_wr !== 8) begin errors++; $display("FAIL wrap_nwr: got %0d want 8", n_wr); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wa[i] !== exp_a[i] || wd[i] !== 16'h5550 + 16'(i)) begin errors++; $display("FAIL wrap_wr%0d: got %h/%h want %h/%h", i, wa[i], wd[i], exp_a[i], 16'h5550 + 16'(i)); end
    end
    tick();
  endtask

  task automatic test_stale_full();
    logic ok;
    acc_full  = 1'b1;
    base_addr = 8'h99;
    start     = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stale_err: got err=%b busy=%b want 1 0", err, busy); end
    ok = 1'b1;
    for (int j = 0; j < 5; j++) begin tick(); if (acc_valid !== 1'b0 || ub_wr_en !== 1'b0 || busy !== 1'b0 || err !== 1'b1) ok = 1'b0; end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stale_quiet: got activity after stale start want none"); end
    acc_full = 1'b0;
    set_data(16'h0100);
    start_job(8'h30);
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stale_restart: got err=%b busy=%b want 0 1", err, busy); end
    advance_to_drain(0);
    collect(0);
    checks++; if (n_wr !== 8 || wd[0] !== 16'h0100 || wa[7] !== 8'h37 || done_k !== 8) begin errors++; $display("FAIL stale_rerun: got n=%0d d0=%h a7=%h dk=%0d want 8 0100 37 8", n_wr, wd[0], wa[7], done_k); end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    set_data(16'h7700);
    start_job(8'h20);
    tick();
    base_addr = 8'h80;
    start     = 1'b1;
    tick();
    start = 1'b0;
    advance_to_drain(2);
    checks++; if (ub_wr_en !== 1'b1 || ub_wr_addr !== 8'h20 || ub_wr_data !== 16'h7700) begin errors++; $display("FAIL ign_start: got en=%b %h/%h want 1 20/7700", ub_wr_en, ub_wr_addr, ub_wr_data); end
    ub_wr_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (ub_wr_en !== 1'b1 || ub_wr_addr !== 8'h23 || ub_wr_data !== 16'h7703) begin errors++; $display("FAIL mid_3writes: got en=%b %h/%h want 1 23/7703", ub_wr_en, ub_wr_addr, ub_wr_data); end
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got busy=%b done=%b err=%b want 0 0 0", busy, done, err); end
    checks++; if (acc_valid !== 1'b0 || acc_output_valid !== 1'b0 || ub_wr_en !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl: got av=%b aov=%b en=%b want 0 0 0", acc_valid, acc_output_valid, ub_wr_en); end
    checks++; if (ub_wr_addr !== 8'h00 || ub_wr_data !== 16'h0000) begin errors++; $display("FAIL mid_rst_bus: got %h/%h want 00/0000", ub_wr_addr, ub_wr_data); end
    reset = 1'b0;
    tick();
    checks++; if (ub_wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_post_rst: got en=%b busy=%b want 0 0", ub_wr_en, busy); end
  endtask

  task automatic test_wait_full();
    logic seen_en, ok;
    int   n;
    set_data(16'h3300);
    start_job(8'h50);
    repeat (12) tick();
    checks++; if (acc_valid !== 1'b1 || acc_output_valid !== 1'b0) begin errors++; $display("FAIL wf_entry: got av=%b aov=%b want 1 0", acc_valid, acc_output_valid); end
    seen_en = 1'b0;
    n       = -1;
`ifdef ACC_DRAIN_TIMEOUT_EN
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (ub_wr_en === 1'b1) seen_en = 1'b1;
      if (done === 1'b1) begin n = k; break; end
    end
    checks++; if (n !== 64) begin errors++; $display("FAIL to_latency: got %0d want 64", n); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", err); end
    checks++; if (seen_en !== 1'b0) begin errors++; $display("FAIL to_no_write: got en seen want none"); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL to_idle: got busy=%b done=%b want 0 0", busy, done); end
`else
    ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (ub_wr_en === 1'b1) seen_en = 1'b1;
      if (done === 1'b1) n = k;
      if (busy !== 1'b1 || acc_valid !== 1'b1 || err !== 1'b0) ok = 1'b0;
    end
    checks++; if (n !== -1) begin errors++; $display("FAIL wf_no_done: got done at %0d want none", n); end
    checks++; if (seen_en !== 1'b0) begin errors++; $display("FAIL wf_no_write: got en seen want none"); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wf_hold: got state change want indefinite wait"); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; acc_full = 1'b0; ub_wr_ready = 1'b1;
    base_addr = 8'h00; acc_data = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_stale_full();
    test_reset_mid_drain();
    test_wait_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
